// File: rtl/ariane_wb_pkg.sv
// ariane_wb_pkg: shared types and constants for the regfile write-back arbiter.
// Provides REG_ADDR_W and the wb_req_t result bundle.
package ariane_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WB_DATA_W  = 64;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0]  data;
    } wb_req_t;

endpackage

// File: rtl/ariane_wb_rr_sel.sv
// ariane_wb_rr_sel: round-robin pick of up to K requests starting at ptr_i.
// Ports: req_i/ptr_i in; gnt_o one-hot set, port_vld_o/port_idx_o per port,
// ptr_next_o = last granted index + 1 (or ptr_i when nothing is granted).
module ariane_wb_rr_sel #(
    parameter int N  = 4,
    parameter int K  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]         req_i,
    input  logic [IW-1:0]        ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [K-1:0]         port_vld_o,
    output logic [K-1:0][IW-1:0] port_idx_o,
    output logic [IW-1:0]        ptr_next_o
);

    always_comb begin
        int   cnt;
        int   idx;
        logic hit;
        gnt_o      = '0;
        port_vld_o = '0;
        port_idx_o = '0;
        ptr_next_o = ptr_i;
        cnt        = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            hit = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (j == idx) hit = req_i[j];
            end
            if (hit && cnt < K) begin
                for (int j = 0; j < N; j++) begin
                    if (j == idx) gnt_o[j] = 1'b1;
                end
                for (int k = 0; k < K; k++) begin
                    if (k == cnt) begin
                        port_vld_o[k] = 1'b1;
                        port_idx_o[k] = IW'(idx);
                    end
                end
                ptr_next_o = IW'((idx + 1) % N);
                cnt        = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/ariane_regfile_wb_arbiter.sv
// ariane_regfile_wb_arbiter: buffers one FU result per source and drives the
// regfile write ports round-robin. Ports: clk_i, rst_ni, flush_i; per-source
// in_valid_i/in_ready_o/in_waddr_i/in_wdata_i, pending_o; per-port
// waddr_o/wdata_o/we_o. Define WB_ARB_BYPASS_EN for same-cycle write of an
// incoming result whose buffer is empty.
module ariane_regfile_wb_arbiter
    import ariane_wb_pkg::*;
#(
    parameter int NR_SOURCES     = 4,
    parameter int NR_WRITE_PORTS = 2,
    parameter int DATA_WIDTH     = 64,
    parameter bit ZERO_REG_ZERO  = 1'b1
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         flush_i,
    input  logic [NR_SOURCES-1:0]                        in_valid_i,
    output logic [NR_SOURCES-1:0]                        in_ready_o,
    input  logic [NR_SOURCES-1:0][REG_ADDR_W-1:0]        in_waddr_i,
    input  logic [NR_SOURCES-1:0][DATA_WIDTH-1:0]        in_wdata_i,
    output logic [NR_WRITE_PORTS-1:0][REG_ADDR_W-1:0]    waddr_o,
    output logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]    wdata_o,
    output logic [NR_WRITE_PORTS-1:0]                    we_o,
    output logic [NR_SOURCES-1:0]                        pending_o
);

    localparam int IW = (NR_SOURCES > 1) ? $clog2(NR_SOURCES) : 1;

    logic [NR_SOURCES-1:0]                 buf_valid_q;
    logic [NR_SOURCES-1:0]                 buf_valid_d;
    logic [NR_SOURCES-1:0][REG_ADDR_W-1:0] buf_addr_q;
    logic [NR_SOURCES-1:0][DATA_WIDTH-1:0] buf_data_q;
    logic [IW-1:0]                         rr_q;
    logic [IW-1:0]                         rr_next;

    logic [NR_SOURCES-1:0]                 bypass;
    logic [NR_SOURCES-1:0]                 req;
    logic [NR_SOURCES-1:0]                 gnt;
    logic [NR_SOURCES-1:0]                 push;
    logic [NR_SOURCES-1:0]                 load;
    logic [NR_SOURCES-1:0][REG_ADDR_W-1:0] cand_addr;
    logic [NR_SOURCES-1:0][DATA_WIDTH-1:0] cand_data;

    logic [NR_WRITE_PORTS-1:0]             port_vld;
    logic [NR_WRITE_PORTS-1:0][IW-1:0]     port_idx;

`ifdef WB_ARB_BYPASS_EN
    assign bypass    = in_valid_i & ~buf_valid_q
                     & {NR_SOURCES{~flush_i}};
    for (genvar s = 0; s < NR_SOURCES; s++) begin : g_cand
        assign cand_addr[s] = buf_valid_q[s] ? buf_addr_q[s]
                                             : in_waddr_i[s];
        assign cand_data[s] = buf_valid_q[s] ? buf_data_q[s]
                                             : in_wdata_i[s];
    end
`else
    assign bypass    = '0;
    assign cand_addr = buf_addr_q;
    assign cand_data = buf_data_q;
`endif

    assign req = buf_valid_q | bypass;

    ariane_wb_rr_sel #(
        .N  (NR_SOURCES),
        .K  (NR_WRITE_PORTS),
        .IW (IW)
    ) i_rr_sel (
        .req_i      (req),
        .ptr_i      (rr_q),
        .gnt_o      (gnt),
        .port_vld_o (port_vld),
        .port_idx_o (port_idx),
        .ptr_next_o (rr_next)
    );

    assign in_ready_o = {NR_SOURCES{~flush_i}} & (~buf_valid_q | gnt);
    assign push       = in_valid_i & in_ready_o;
    // A granted result with an empty buffer went out on the bypass path.
    assign load       = push & ~(gnt & ~buf_valid_q);
    assign buf_valid_d = flush_i ? '0 : ((buf_valid_q & ~gnt) | load);
    assign pending_o   = buf_valid_q;

    always_comb begin
        logic [REG_ADDR_W-1:0] a;
        logic                  w;
        we_o    = '0;
        waddr_o = '0;
        wdata_o = '0;
        for (int k = 0; k < NR_WRITE_PORTS; k++) begin
            a = cand_addr[port_idx[k]];
            w = port_vld[k] & ~flush_i;
            // x0 results still use up their port slot, just without a write.
            if (ZERO_REG_ZERO && a == '0) w = 1'b0;
            we_o[k] = w;
            if (w) begin
                waddr_o[k] = a;
                wdata_o[k] = cand_data[port_idx[k]];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_valid_q <= '0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            rr_q        <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            for (int s = 0; s < NR_SOURCES; s++) begin
                if (load[s]) begin
                    buf_addr_q[s] <= in_waddr_i[s];
                    buf_data_q[s] <= in_wdata_i[s];
                end
            end
            if (!flush_i && |gnt) rr_q <= rr_next;
        end
    end

endmodule

// File: tb/tb_ariane_regfile_wb_arbiter.sv
// tb_ariane_regfile_wb_arbiter: directed vector table plus reset sequences
// for the write-back arbiter (4 sources, 2 write ports, 64-bit data).
module tb_ariane_regfile_wb_arbiter;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 flush_i;
    logic [3:0]           in_valid_i;
    logic [3:0]           in_ready_o;
    logic [3:0][4:0]      in_waddr_i;
    logic [3:0][63:0]     in_wdata_i;
    logic [1:0][4:0]      waddr_o;
    logic [1:0][63:0]     wdata_o;
    logic [1:0]           we_o;
    logic [3:0]           pending_o;

    int n_chk  = 0;
    int n_pass = 0;

    ariane_regfile_wb_arbiter #(
        .NR_SOURCES     (4),
        .NR_WRITE_PORTS (2),
        .DATA_WIDTH     (64),
        .ZERO_REG_ZERO  (1'b1)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_waddr_i (in_waddr_i),
        .in_wdata_i (in_wdata_i),
        .waddr_o    (waddr_o),
        .wdata_o    (wdata_o),
        .we_o       (we_o),
        .pending_o  (pending_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]      v;
        logic [3:0][4:0] a;
        logic [3:0][7:0] d;
        logic            fl;
        logic [1:0]      we;
        logic [1:0][4:0] wa;
        logic [1:0][7:0] wd;
        logic [3:0]      rdy;
        logic [3:0]      pend;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(
        input logic [3:0]  v,
        input logic [19:0] a,
        input logic [31:0] d,
        input logic        fl,
        input logic [1:0]  we,
        input logic [9:0]  wa,
        input logic [15:0] wd,
        input logic [3:0]  rdy,
        input logic [3:0]  pend
    );
        vec_t t;
        t.v = v; t.a = a; t.d = d; t.fl = fl;
        t.we = we; t.wa = wa; t.wd = wd;
        t.rdy = rdy; t.pend = pend;
        tbl.push_back(t);
    endfunction

    task automatic chk(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input logic [3:0] v,
                         input logic [19:0] a,
                         input logic [31:0] d,
                         input logic fl);
        logic [3:0][4:0] aa;
        logic [3:0][7:0] dd;
        aa = a;
        dd = d;
        in_valid_i = v;
        flush_i    = fl;
        for (int s = 0; s < 4; s++) begin
            in_waddr_i[s] = aa[s];
            in_wdata_i[s] = 64'(dd[s]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [1:0][63:0] ewd;
        rst_ni = 1'b0;
        drive(4'h0, 20'h0, 32'h0, 1'b0);
        #1;
        chk("rst we", 128'(we_o), 128'(2'b00));
        chk("rst pend", 128'(pending_o), 128'(4'h0));
        chk("rst rdy", 128'(in_ready_o), 128'(4'hF));
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

`ifndef WB_ARB_BYPASS_EN
        //   v     a{3,2,1,0}               d{3,2,1,0}     fl we  wa{1,0}        wd{1,0}     rdy   pend
        add(4'h0, 20'h0,                    32'h0,          0, 2'b00, 10'h0,          16'h0,      4'hF, 4'h0);
        add(4'hF, {5'd4,5'd3,5'd2,5'd1},    32'h44332211,   0, 2'b00, 10'h0,          16'h0,      4'hF, 4'h0);
        add(4'h0, 20'h0,                    32'h0,          0, 2'b11, {5'd2,5'd1},    16'h2211,   4'h3, 4'hF);
        add(4'h0, 20'h0,                    32'h0,          0, 2'b11, {5'd4,5'd3},    16'h4433,   4'hF, 4'hC);
        add(4'h5, {5'd0,5'd7,5'd0,5'd7},    32'h00020001,   0, 2'b00, 10'h0,          16'h0,      4'hF, 4'h0);
        add(4'h0, 20'h0,                    32'h0,          0, 2'b11, {5'd7,5'd7},    16'h0201,   4'hF, 4'h5);
        add(4'h2, {5'd0,5'd0,5'd5,5'd0},    32'h0000AB00,   0, 2'b00, 10'h0,          16'h0,      4'hF, 4'h0);
        add(4'h0, 20'h0,                    32'h0,          0, 2'b01, {5'd0,5'd5},    16'h00AB,   4'hF, 4'h2);
        add(4'h1, 20'h0,                    32'h00000099,   0, 2'b00, 10'h0,          16'h0,      4'hF, 4'h0);
        add(4'h0, 20'h0,                    32'h0,          0, 2'b00, 10'h0,          16'h0,      4'hF, 4'h1);
        add(4'h1, {5'd0,5'd0,5'd0,5'd9},    32'h00000005,   0, 2'b00, 10'h0,          16'h0,      4'hF, 4'h0);
        add(4'h1, {5'd0,5'd0,5'd0,5'd10},   32'h00000006,   0, 2'b01, {5'd0,5'd9},    16'h0005,   4'hF, 4'h1);
        add(4'h0, 20'h0,                    32'h0,          0, 2'b01, {5'd0,5'd10},   16'h0006,   4'hF, 4'h1);
        add(4'h0, 20'h0,                    32'h0,          0, 2'b00, 10'h0,          16'h0,      4'hF, 4'h0);
        add(4'h7, {5'd0,5'd3,5'd2,5'd1},    32'h00332211,   0, 2'b00, 10'h0,          16'h0,      4'hF, 4'h0);
        add(4'h8, {5'd31,5'd0,5'd0,5'd0},   32'hEE000000,   1, 2'b00, 10'h0,          16'h0,      4'h0, 4'h7);
        add(4'h0, 20'h0,                    32'h0,          0, 2'b00, 10'h0,          16'h0,      4'hF, 4'h0);
        add(4'h3, {5'd0,5'd0,5'd6,5'd4},    32'h00008877,   0, 2'b00, 10'h0,          16'h0,      4'hF, 4'h0);
        add(4'h0, 20'h0,                    32'h0,          0, 2'b11, {5'd4,5'd6},    16'h7788,   4'hF, 4'h3);
        add(4'h0, 20'h0,                    32'h0,          0, 2'b00, 10'h0,          16'h0,      4'hF, 4'h0);

        foreach (tbl[i]) begin
            @(negedge clk_i);
            drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].fl);
            #1;
            for (int k = 0; k < 2; k++) ewd[k] = 64'(tbl[i].wd[k]);
            chk($sformatf("v%0d we", i), 128'(we_o), 128'(tbl[i].we));
            chk($sformatf("v%0d waddr", i), 128'(waddr_o), 128'(tbl[i].wa));
            chk($sformatf("v%0d wdata", i), 128'(wdata_o), 128'(ewd));
            chk($sformatf("v%0d ready", i), 128'(in_ready_o), 128'(tbl[i].rdy));
            chk($sformatf("v%0d pend", i), 128'(pending_o), 128'(tbl[i].pend));
        end
`else
        @(negedge clk_i);
        drive(4'h2, {5'd0,5'd0,5'd5,5'd0}, 32'h0000AB00, 1'b0);
        #1;
        chk("byp we", 128'(we_o), 128'(2'b01));
        chk("byp waddr", 128'(waddr_o[0]), 128'(5'd5));
        chk("byp wdata", 128'(wdata_o[0]), 128'(64'hAB));
        chk("byp ready", 128'(in_ready_o), 128'(4'hF));
        @(negedge clk_i);
        drive(4'h0, 20'h0, 32'h0, 1'b0);
        #1;
        chk("byp pend", 128'(pending_o), 128'(4'h0));
        chk("byp idle", 128'(we_o), 128'(2'b00));
`endif

        @(negedge clk_i);
        drive(4'h3, {5'd0,5'd0,5'd4,5'd3}, 32'h00001213, 1'b0);
        @(negedge clk_i);
        drive(4'h0, 20'h0, 32'h0, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst we", 128'(we_o), 128'(2'b00));
        chk("arst pend", 128'(pending_o), 128'(4'h0));
        chk("arst rdy", 128'(in_ready_o), 128'(4'hF));
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("post we", 128'(we_o), 128'(2'b00));
        @(negedge clk_i);
        #1;
        chk("idle we", 128'(we_o), 128'(2'b00));
        chk("idle pend", 128'(pending_o), 128'(4'h0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
